prim_regslice: RTL
==================

// Module: prim_regslice
// PURPOSE
//  Full register slice for the valid/ready stream protocol: registers both the forward path (valid/data) and the
//  backward path (ready), so no combinational path runs between upstream and downstream ports.
//  Two entries (output reg + skid reg) give full 1 beat/cycle throughput under back-pressure.
//  Inserted where urdy_o timing (drdy_i fan-in) must be broken, e.g. between pipeline stages and long bus hops.
// PARAMETERS
//  WIDTH            32  payload width in bits
//  ZERO_ON_INVALID  0   1: ddat_o forced to 0 whenever dvld_o=0; 0: ddat_o holds last value
//  CNT_W            16  width of stall_cnt_o (only meaningful with PRIM_REGSLICE_STALLCNT_EN)
// PORTS
//  clk          in   1      clock, all state on posedge
//  reset        in   1      asynchronous, active-high reset
//  urdy_o       out  1      upstream ready, registered
//  uvld_i       in   1      upstream valid
//  udat_i       in   WIDTH  upstream payload
//  drdy_i       in   1      downstream ready
//  dvld_o       out  1      downstream valid, registered
//  ddat_o       out  WIDTH  downstream payload, registered
//  stall_cnt_o  out  CNT_W  saturating count of stalled downstream cycles
// BEHAVIOUR
//  - Beat: upstream = urdy_o&&uvld_i at posedge clk; downstream = dvld_o&&drdy_i at posedge clk.
//  - Reset (async, while high): state=EMPTY, urdy_o=0, dvld_o=0, ddat_o=0, skid=0, stall_cnt_o=0.
//    urdy_o rises at first posedge after reset release. Reset mid-operation discards all held entries.
//  - States: EMPTY (0 entries), BUSY (1 entry in ddat_o), FULL (ddat_o + skid). Encoded 2 bits, 3 legal.
//  - Outputs: dvld_o = (state!=EMPTY); urdy_o = (state!=FULL), both as flops, not decoded combinationally.
//  - EMPTY: up beat -> ddat_o<=udat_i, BUSY. Else stay.
//  - BUSY: up&down -> ddat_o<=udat_i, stay BUSY. up only -> skid<=udat_i, FULL, urdy_o<=0.
//          down only -> EMPTY. neither -> stay, ddat_o unchanged.
//  - FULL: uvld_i ignored (urdy_o=0). down beat -> ddat_o<=skid, BUSY, urdy_o<=1. Else stay.
//  - Latency: upstream beat to dvld_o = 1 cycle. Throughput 1 beat/cycle when drdy_i=1.
//  - Order preserved; no beat dropped or duplicated. ddat_o stable while dvld_o&&!drdy_i.
//  - ZERO_ON_INVALID=1: entry to EMPTY writes ddat_o<=0; skid<=0 when leaving FULL.
//  - Upstream may drop/change uvld_i/udat_i freely while urdy_o=0 (no beat occurs).
// CONFIGURATION
//  PRIM_REGSLICE_STALLCNT_EN defined: stall_cnt_o increments each posedge with dvld_o&&!drdy_i,
//    saturates at 2^CNT_W-1, cleared only by reset. Counter flops otherwise unused.
//  Undefined: stall_cnt_o tied to 0, no counter logic synthesised. Data path identical either way.
// TESTING
//  1. Stream 1..8, uvld_i=1, drdy_i=1 -> dvld_o high 1 cycle after first beat, ddat_o=1..8 back-to-back,
//     urdy_o constant 1.
//  2. Send A,B with drdy_i=0 -> state FULL, urdy_o=0 cycle after B accepted; raise drdy_i -> ddat_o=A then B,
//     urdy_o=1 after A's downstream beat.
//  3. In FULL hold uvld_i=1, udat_i=C for 3 cycles, drdy_i=0 -> C not accepted; after drain, C emitted once.
//  4. Assert reset asynchronously while FULL -> dvld_o=0, urdy_o=0, ddat_o=0 before next edge; release ->
//     urdy_o=1 at next posedge, no stale A/B emitted.
//  5. ZERO_ON_INVALID=1: send 0x5A, drain -> ddat_o=0 when dvld_o=0; ZERO_ON_INVALID=0 -> ddat_o stays 0x5A.
//  6. CNT_W=3, macro on: dvld_o=1, drdy_i=0 for 10 cycles -> stall_cnt_o=7 (saturated); macro off -> 0.

Source files
------------

// File: rtl/prim_regslice.sv
// rtl/prim_regslice.sv - two-entry valid/ready register slice with registered forward and backward paths
// Optional stall counter: define PRIM_REGSLICE_STALLCNT_EN.
module prim_regslice #(
    parameter int WIDTH           = 32,
    parameter bit ZERO_ON_INVALID = 1'b0,
    parameter int CNT_W           = 16
) (
    input  logic             clk,
    input  logic             reset,
    output logic             urdy_o,
    input  logic             uvld_i,
    input  logic [WIDTH-1:0] udat_i,
    input  logic             drdy_i,
    output logic             dvld_o,
    output logic [WIDTH-1:0] ddat_o,
    output logic [CNT_W-1:0] stall_cnt_o
);

    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        BUSY  = 2'b01,
        FULL  = 2'b10
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] skid;
    logic             up_beat;
    logic             dn_beat;
    logic             load_out_up;
    logic             load_out_skid;
    logic             load_skid;
    logic             clr_out;
    logic             clr_skid;

    assign up_beat = urdy_o & uvld_i;
    assign dn_beat = dvld_o & drdy_i;

    always_comb begin
        state_nxt     = state;
        load_out_up   = 1'b0;
        load_out_skid = 1'b0;
        load_skid     = 1'b0;
        clr_out       = 1'b0;
        clr_skid      = 1'b0;
        case (state)
            EMPTY: begin
                if (up_beat) begin
                    load_out_up = 1'b1;
                    state_nxt   = BUSY;
                end
            end
            BUSY: begin
                if (up_beat && dn_beat) begin
                    load_out_up = 1'b1;
                end else if (up_beat) begin
                    load_skid = 1'b1;
                    state_nxt = FULL;
                end else if (dn_beat) begin
                    clr_out   = ZERO_ON_INVALID;
                    state_nxt = EMPTY;
                end
            end
            FULL: begin
                if (dn_beat) begin
                    load_out_skid = 1'b1;
                    clr_skid      = ZERO_ON_INVALID;
                    state_nxt     = BUSY;
                end
            end
            default: state_nxt = EMPTY;
        endcase
    end

    // Handshake outputs are flops loaded from the next state, so no port sees a combinational path.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= EMPTY;
            urdy_o <= 1'b0;
            dvld_o <= 1'b0;
        end else begin
            state  <= state_nxt;
            urdy_o <= (state_nxt != FULL);
            dvld_o <= (state_nxt != EMPTY);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ddat_o <= '0;
            skid   <= '0;
        end else begin
            if (load_out_up) begin
                ddat_o <= udat_i;
            end else if (load_out_skid) begin
                ddat_o <= skid;
            end else if (clr_out) begin
                ddat_o <= '0;
            end
            if (load_skid) begin
                skid <= udat_i;
            end else if (clr_skid) begin
                skid <= '0;
            end
        end
    end

`ifdef PRIM_REGSLICE_STALLCNT_EN
    logic [CNT_W-1:0] stall_cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cnt <= '0;
        end else if (dvld_o && !drdy_i && (stall_cnt != {CNT_W{1'b1}})) begin
            stall_cnt <= stall_cnt + CNT_W'(1);
        end
    end

    assign stall_cnt_o = stall_cnt;
`else
    assign stall_cnt_o = '0;
`endif

endmodule
